// File: rtl/ftdi_245fifo_chip_emu.sv
// Chip-side emulation of the FTDI synchronous 245-FIFO bus, with PC-side h2d/d2h stream ports.
// Optional: define FTDI_EMU_STALL_EN for LFSR-driven stalls on usb_rxf/usb_txe.

module ftdi_245fifo_chip_emu #(
    parameter int C_DEXP  = 0,
    parameter int RX_AEXP = 9,
    parameter int TX_AEXP = 9
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      h2d_valid,
    output logic                      h2d_ready,
    input  logic [(8<<C_DEXP)-1:0]    h2d_data,
    output logic                      d2h_valid,
    input  logic                      d2h_ready,
    output logic [(8<<C_DEXP)-1:0]    d2h_data,
    output logic                      usb_rxf,
    output logic                      usb_txe,
    input  logic                      usb_oe,
    input  logic                      usb_rd,
    input  logic                      usb_wr,
    input  logic [(1<<C_DEXP)-1:0]    usb_be,
    input  logic [(8<<C_DEXP)-1:0]    usb_data_i,
    output logic [(8<<C_DEXP)-1:0]    usb_data_o,
    output logic                      usb_data_t,
    output logic [2:0]                err_flags
);
    localparam int DW  = 8 << C_DEXP;
    localparam int RXD = 1 << RX_AEXP;
    localparam int TXD = 1 << TX_AEXP;
    localparam logic [RX_AEXP:0] RX_FULL = (RX_AEXP+1)'(RXD);
    localparam logic [TX_AEXP:0] TX_FULL = (TX_AEXP+1)'(TXD);

    logic [DW-1:0]        rx_mem [0:RXD-1];
    logic [DW-1:0]        tx_mem [0:TXD-1];
    logic [RX_AEXP-1:0]   rx_wp_q, rx_rp_q;
    logic [TX_AEXP-1:0]   tx_wp_q, tx_rp_q;
    logic [RX_AEXP:0]     rx_cnt_q, rx_cnt_d;
    logic [TX_AEXP:0]     tx_cnt_q, tx_cnt_d;
    logic                 rx_rdy_q, rxf_q, txe_q;
    logic [2:0]           err_q;
    logic [(1<<C_DEXP)-1:0] be_q;
    logic                 rx_push, rx_pop, tx_push, tx_pop, tx_nempty;
    logic                 stall;
    logic                 unused_be;

`ifdef FTDI_EMU_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1; stalls roughly one cycle in four.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Strobes only act while the matching flag is low, so a stall never loses or duplicates a word.
    assign rx_push   = h2d_valid & rx_rdy_q;
    assign rx_pop    = ~usb_rd & ~usb_oe & ~rxf_q & (rx_cnt_q != '0);
    assign tx_nempty = (tx_cnt_q != '0);
    assign tx_push   = ~usb_wr & ~txe_q & (tx_cnt_q != TX_FULL);
    assign tx_pop    = tx_nempty & d2h_ready;

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + (RX_AEXP+1)'(1);
        else if (rx_pop & ~rx_push) rx_cnt_d = rx_cnt_q - (RX_AEXP+1)'(1);
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push & ~tx_pop)      tx_cnt_d = tx_cnt_q + (TX_AEXP+1)'(1);
        else if (tx_pop & ~tx_push) tx_cnt_d = tx_cnt_q - (TX_AEXP+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= h2d_data;
        if (tx_push) tx_mem[tx_wp_q] <= usb_data_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            rx_rdy_q <= 1'b0;
            rxf_q    <= 1'b1;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            txe_q    <= 1'b1;
            err_q    <= '0;
            be_q     <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + RX_AEXP'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + RX_AEXP'(1);
            if (tx_push) tx_wp_q <= tx_wp_q + TX_AEXP'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + TX_AEXP'(1);
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            // Flags reflect occupancy after this edge, so the last pop raises rxf immediately.
            rx_rdy_q <= (rx_cnt_d != RX_FULL);
            rxf_q    <= stall | (rx_cnt_d == '0);
            txe_q    <= stall | (tx_cnt_d == TX_FULL);
            if (~usb_wr) be_q <= usb_be;
            err_q    <= err_q | {~usb_wr & ~usb_oe, ~usb_wr & txe_q, ~usb_rd & usb_oe};
        end
    end

    assign unused_be  = ^be_q;

    assign h2d_ready  = rx_rdy_q;
    assign d2h_valid  = tx_nempty;
    assign d2h_data   = tx_nempty ? tx_mem[tx_rp_q] : '0;
    assign usb_data_o = (rx_cnt_q != '0) ? rx_mem[rx_rp_q] : '0;
    assign usb_data_t = ~usb_oe;
    assign usb_rxf    = rxf_q;
    assign usb_txe    = txe_q;
    assign err_flags  = err_q;

endmodule
